// File: rtl/i2c_pkg.sv
// ============================================================================
//  Module   : i2c_pkg
//  Purpose  : Definitions shared by the I2C target and controller: state
//             encoding, bit-counter width, R/W bit position and the address
//             match helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_ACK  = 3'd2,
    ST_WRITE     = 3'd3,
    ST_WRITE_ACK = 3'd4,
    ST_READ      = 3'd5,
    ST_READ_ACK  = 3'd6,
    ST_WAIT_STOP = 3'd7
  } i2c_state_e;

  // Bit counter wraps 7 -> 0 on every byte boundary.
  localparam int BIT_CNT_W = 3;

  // Position of the R/W flag inside the header byte (1 = read).
  localparam int RW_BIT = 0;

  // General call (address 0) and the 10-bit address prefix 11110xx are never
  // claimed, even if the own address were configured to one of them.
  function automatic logic addr_match(input logic [6:0] rx_addr,
                                      input logic [6:0] own_addr);
    return (rx_addr == own_addr) && (rx_addr != 7'h00) &&
           (rx_addr[6:2] != 5'b11110);
  endfunction

endpackage

`default_nettype wire

// File: rtl/InOut.sv
// ============================================================================
//  Module   : InOut
//  Purpose  : Tristate pad primitive. Drives out_i onto the pad while oe_i is
//             high, otherwise leaves it high-Z. The pad level is always
//             returned on in_o.
//  Ports    : pad (inout), out_i, oe_i (in), in_o (out)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module InOut (
  inout  wire  pad,
  input  logic out_i,
  input  logic oe_i,
  output logic in_o
);

  assign pad  = oe_i ? out_i : 1'bz;
  assign in_o = pad;

endmodule

`default_nettype wire

// File: rtl/i2c_bus_sync.sv
// ============================================================================
//  Module   : i2c_bus_sync
//  Purpose  : Synchronises SCL/SDA into the system clock domain and derives
//             the bus events: SCL rise/fall, START and STOP.
//  Ports    : clk_i            system clock
//             scl_i, sda_i     raw pin levels
//             sda_o            synchronised SDA level
//             scl_rise_o, scl_fall_o, start_o, stop_o   one-cycle strobes
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_prev_q;
  logic                   sda_prev_q;
  logic                   scl_s;
  logic                   sda_s;

  // The data path is intentionally not reset: it keeps tracking the pins
  // through a reset, so releasing reset in the middle of a transfer cannot
  // fabricate an edge, START or STOP out of a stale reset value.
  always_ff @(posedge clk_i) begin
    scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
    sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
    scl_prev_q <= scl_s;
    sda_prev_q <= sda_s;
  end

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  assign sda_o      = sda_s;
  assign scl_rise_o = scl_s & ~scl_prev_q;
  assign scl_fall_o = ~scl_s & scl_prev_q;
  // SCL must be high on both samples, so START/STOP can never share a cycle
  // with an SCL edge.
  assign start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

`default_nettype wire

// File: rtl/i2c_target.sv
// ============================================================================
//  Module   : i2c_target
//  Purpose  : I2C target answering one 7-bit address. ACKs its address and
//             every written byte, hands written bytes to the fabric and
//             shifts fabric bytes out on reads. Open-drain, no clock
//             stretching.
//  Ports    : CLK_100MHz, rst      clock / synchronous active-high reset
//             i2c_scl, i2c_sda     bus pins (SCL never driven, SDA 0 or Z)
//             tx_data              read byte, sampled on the tx_req cycle
//             rx_data, rx_valid    last written byte and its update pulse
//             tx_req               tx_data captured this cycle
//             addr_hit, rw         address matched pulse, R/W of the transfer
//             busy                 addressed, until STOP or next START
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDR        = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       CLK_100MHz,
  input  logic       rst,
  inout  wire        i2c_scl,
  inout  wire        i2c_sda,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_req,
  output logic       addr_hit,
  output logic       rw,
  output logic       busy
);

  logic scl_in, sda_in, sda_s;
  logic scl_rise, scl_fall, start_evt, stop_evt;

  i2c_state_e           state_q, state_d;
  logic [BIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]           shift_q, shift_d;
  logic                 sda_low_q, sda_low_d;
  logic [7:0]           rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 tx_req_q, tx_req_d;
  logic                 addr_hit_q, addr_hit_d;
  logic                 rw_q, rw_d;
  logic                 busy_q, busy_d;
  logic [7:0]           hdr;

  InOut u_scl_pad (
    .pad   (i2c_scl),
    .out_i (1'b1),
    .oe_i  (1'b0),
    .in_o  (scl_in)
  );

  InOut u_sda_pad (
    .pad   (i2c_sda),
    .out_i (1'b0),
    .oe_i  (sda_low_q),
    .in_o  (sda_in)
  );

  i2c_bus_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i      (CLK_100MHz),
    .scl_i      (scl_in),
    .sda_i      (sda_in),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_evt),
    .stop_o     (stop_evt)
  );

  // Byte as it stands once the bit being sampled now is shifted in.
  assign hdr = {shift_q, sda_s};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    sda_low_d  = sda_low_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    addr_hit_d = 1'b0;
    rw_d       = rw_q;
    busy_d     = busy_q;

    if (start_evt) begin
      state_d   = ST_ADDR;
      cnt_d     = '0;
      sda_low_d = 1'b0;
      busy_d    = 1'b0;
    end else if (stop_evt) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      sda_low_d = 1'b0;
      busy_d    = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_WAIT_STOP: begin
        end

        ST_ADDR: begin
          if (scl_rise) begin
            shift_d = hdr[6:0];
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == '1) begin
              if (addr_match(hdr[7:1], ADDR)) begin
                state_d    = ST_ADDR_ACK;
                addr_hit_d = 1'b1;
                rw_d       = hdr[RW_BIT];
                busy_d     = 1'b1;
              end else begin
                state_d = ST_WAIT_STOP;
              end
            end
          end
        end

        // First fall ends the 8th bit: pull SDA low for the ACK slot.
        // Second fall ends the ACK slot: release, or start a read byte.
        ST_ADDR_ACK, ST_WRITE_ACK: begin
          if (scl_fall) begin
            if (!sda_low_q) begin
              sda_low_d = 1'b1;
            end else begin
              sda_low_d = 1'b0;
              cnt_d     = '0;
              if (state_q == ST_ADDR_ACK && rw_q) begin
                state_d   = ST_READ;
                shift_d   = tx_data[6:0];
                tx_req_d  = 1'b1;
                sda_low_d = ~tx_data[7];
              end else begin
                state_d = ST_WRITE;
              end
            end
          end
        end

        ST_WRITE: begin
          if (scl_rise) begin
            shift_d = hdr[6:0];
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == '1) begin
              rx_data_d  = hdr;
              rx_valid_d = 1'b1;
              state_d    = ST_WRITE_ACK;
            end
          end
        end

        // Bit 7 went out on entry; each fall presents the next bit and the
        // eighth fall hands SDA back to the controller for its ACK.
        ST_READ: begin
          if (scl_fall) begin
            cnt_d   = cnt_q + 1'b1;
            shift_d = {shift_q[5:0], 1'b0};
            if (cnt_q == '1) begin
              sda_low_d = 1'b0;
              state_d   = ST_READ_ACK;
            end else begin
              sda_low_d = ~shift_q[6];
            end
          end
        end

        // A fall here is only reachable after an ACK was seen on the rise.
        ST_READ_ACK: begin
          if (scl_rise && sda_s) begin
            state_d = ST_WAIT_STOP;
          end else if (scl_fall) begin
            state_d   = ST_READ;
            cnt_d     = '0;
            shift_d   = tx_data[6:0];
            tx_req_d  = 1'b1;
            sda_low_d = ~tx_data[7];
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_100MHz) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      sda_low_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      addr_hit_q <= 1'b0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      sda_low_q  <= sda_low_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      addr_hit_q <= addr_hit_d;
      rw_q       <= rw_d;
      busy_q     <= busy_d;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_req   = tx_req_q;
  assign addr_hit = addr_hit_q;
  assign rw       = rw_q;
  assign busy     = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_i2c_target.sv
// ============================================================================
//  Module   : tb_i2c_target
//  Purpose  : Bench for i2c_target: a bit-banged I2C controller drives
//             directed and random transactions; expected target events are
//             queued and a monitor compares them as the target raises them.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_i2c_target;

  localparam logic [6:0] TGT = 7'h42;
  localparam int         Q   = 8;   // system clocks per quarter SCL bit

  logic       clk = 1'b0;
  logic       rst;
  logic       ctl_scl_low;
  logic       ctl_sda_low;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       rx_valid, tx_req, addr_hit, rw, busy;
  wire        scl;
  wire        sda;

  always #5 clk = ~clk;

  assign scl = ctl_scl_low ? 1'b0 : 1'bz;
  assign sda = ctl_sda_low ? 1'b0 : 1'bz;
  pullup pu_scl (scl);
  pullup pu_sda (sda);

  i2c_target #(
    .ADDR        (TGT),
    .SYNC_STAGES (2)
  ) dut (
    .CLK_100MHz (clk),
    .rst        (rst),
    .i2c_scl    (scl),
    .i2c_sda    (sda),
    .tx_data    (tx_data),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_req     (tx_req),
    .addr_hit   (addr_hit),
    .rw         (rw),
    .busy       (busy)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic       q_hit[$];   // expected rw per address match
  logic [7:0] q_rx[$];    // expected written bytes
  int         q_tx[$];    // one entry per expected tx_req

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Scoreboard monitor: every output strobe must match the head of its queue.
  always @(negedge clk) begin
    if (addr_hit) begin
      check("addr_hit expected", 32'(q_hit.size() > 0), 1);
      check("busy at addr_hit", busy, 1);
      if (q_hit.size() > 0) check("addr_hit rw", rw, q_hit.pop_front());
    end
    if (rx_valid) begin
      check("rx_valid expected", 32'(q_rx.size() > 0), 1);
      if (q_rx.size() > 0) check("rx_data", rx_data, q_rx.pop_front());
    end
    if (tx_req) begin
      check("tx_req expected", 32'(q_tx.size() > 0), 1);
      if (q_tx.size() > 0) void'(q_tx.pop_front());
    end
  end

  initial begin
    #10ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "time limit");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    ctl_sda_low = 1'b0; tick(Q);
    ctl_scl_low = 1'b0; tick(Q);
    ctl_sda_low = 1'b1; tick(Q);
    ctl_scl_low = 1'b1; tick(Q);
  endtask

  task automatic bus_stop();
    ctl_sda_low = 1'b1; tick(Q);
    ctl_scl_low = 1'b0; tick(Q);
    ctl_sda_low = 1'b0; tick(Q);
  endtask

  // One SCL period; b=1 releases SDA, r is the bus level mid-high-phase.
  task automatic bit_xfer(input logic b, output logic r);
    ctl_sda_low = ~b;   tick(Q);
    ctl_scl_low = 1'b0; tick(Q);
    @(negedge clk);
    r = sda;
    tick(Q);
    ctl_scl_low = 1'b1; tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic acked);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], r);
    bit_xfer(1'b1, r);
    acked = ~r;
  endtask

  // Reference model: the target claims only its own address, ACKs every
  // written byte and returns the supplied bytes until the controller NACKs.
  task automatic do_txn(input logic [6:0] a7, input logic rd, input int n,
                        input logic [7:0] d0, input logic [7:0] d1,
                        input logic [7:0] d2, input bit do_stop);
    logic [7:0] bytes [3];
    logic [7:0] got;
    logic       r, acked, exp_ack;
    bytes[0] = d0; bytes[1] = d1; bytes[2] = d2;
    exp_ack = (a7 == TGT);
    if (rd) tx_data = bytes[0];
    bus_start();
    if (exp_ack) q_hit.push_back(rd);
    if (exp_ack && rd) q_tx.push_back(0);
    send_byte({a7, rd}, acked);
    check("address ack", acked, exp_ack);
    if (!exp_ack) begin
      if (!rd) begin
        for (int k = 0; k < n; k++) begin
          send_byte(bytes[k], acked);
          check("no ack after mismatch", acked, 0);
        end
      end
    end else if (!rd) begin
      for (int k = 0; k < n; k++) begin
        q_rx.push_back(bytes[k]);
        send_byte(bytes[k], acked);
        check("write data ack", acked, 1);
      end
    end else begin
      for (int k = 0; k < n; k++) begin
        for (int i = 7; i >= 0; i--) begin
          bit_xfer(1'b1, r);
          got[i] = r;
        end
        check("read byte", got, bytes[k]);
        if (k < n - 1) begin
          tx_data = bytes[k+1];
          q_tx.push_back(k + 1);
        end
        bit_xfer(k == n - 1, r);
      end
    end
    if (exp_ack) check("busy during transfer", busy, 1);
    if (do_stop) begin
      bus_stop();
      tick(2);
      check("busy after stop", busy, 0);
    end
  endtask

  initial begin
    logic       r, acked;
    logic [6:0] a7;
    logic       rd;
    int         n;

    rst = 1'b1; ctl_scl_low = 1'b0; ctl_sda_low = 1'b0; tx_data = 8'h00;
    tick(10);
    rst = 1'b0;
    tick(2);
    check("reset rx_data", rx_data, 0);
    check("reset rx_valid", rx_valid, 0);
    check("reset tx_req", tx_req, 0);
    check("reset addr_hit", addr_hit, 0);
    check("reset rw", rw, 0);
    check("reset busy", busy, 0);
    check("reset sda released", sda, 1);

    do_txn(TGT, 1'b0, 1, 8'hA5, 8'h00, 8'h00, 1'b1);        // write 0x84,0xA5
    check("rx_data after write", rx_data, 8'hA5);
    do_txn(TGT, 1'b1, 1, 8'h3C, 8'h00, 8'h00, 1'b1);        // read 0x85 -> 0x3C
    do_txn(7'h48, 1'b0, 1, 8'h11, 8'h00, 8'h00, 1'b1);      // 0x90 mismatch
    do_txn(TGT, 1'b0, 1, 8'h01, 8'h00, 8'h00, 1'b0);        // repeated START
    do_txn(TGT, 1'b1, 1, 8'hF0, 8'h00, 8'h00, 1'b1);
    check("rx_data after repeated start", rx_data, 8'h01);
    do_txn(TGT, 1'b1, 2, 8'h12, 8'h34, 8'h00, 1'b1);        // two-byte read

    // Reset while the target is holding SDA low during a read.
    tx_data = 8'h00;
    bus_start();
    q_hit.push_back(1'b1);
    q_tx.push_back(0);
    send_byte({TGT, 1'b1}, acked);
    check("rst-read address ack", acked, 1);
    bit_xfer(1'b1, r);
    check("rst-read bit7", r, 0);
    check("sda driven before rst", sda, 0);
    rst = 1'b1;
    tick(1);
    check("sda released 1 clk after rst", sda, 1);
    tick(3);
    rst = 1'b0;
    tick(1);
    check("busy cleared by rst", busy, 0);
    bus_stop();

    // Reset during the 4th data bit of a write; the byte must be dropped.
    bus_start();
    q_hit.push_back(1'b0);
    send_byte({TGT, 1'b0}, acked);
    check("rst-write address ack", acked, 1);
    for (int i = 7; i >= 5; i--) bit_xfer(1'(8'hC3 >> i), r);
    ctl_sda_low = 1'b1; tick(Q);   // bit 4 of 0xC3 is 0
    ctl_scl_low = 1'b0; tick(Q);
    rst = 1'b1;
    tick(2);
    check("sda released in rst", sda, 0);   // controller itself holds 0
    rst = 1'b0;
    tick(Q);
    ctl_scl_low = 1'b1; tick(Q);
    for (int i = 3; i >= 0; i--) bit_xfer(1'(8'hC3 >> i), r);
    bit_xfer(1'b1, r);
    check("no ack after rst", r, 1);
    bus_stop();
    tick(2);
    do_txn(TGT, 1'b0, 2, 8'h5A, 8'hC3, 8'h00, 1'b1);

    for (int t = 0; t < 14; t++) begin
      a7 = ($urandom_range(0, 1) == 1) ? TGT : 7'($urandom);
      rd = 1'($urandom_range(0, 1));
      n  = int'($urandom_range(1, 3));
      do_txn(a7, rd, n, 8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
    end

    tick(20);
    check("pending addr_hit", q_hit.size(), 0);
    check("pending rx_valid", q_rx.size(), 0);
    check("pending tx_req", q_tx.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/i2c_target.md
# i2c_target

I2C target (slave) responder that answers a single 7-bit address on the same two-wire bus driven by the team's I2C controller. It oversamples SCL/SDA on the 100 MHz system clock, detects START/STOP, ACKs its address, and presents received bytes to fabric logic. On reads it shifts fabric-supplied bytes out. Open-drain only: SDA is driven low or released, SCL is never driven, and there is no clock stretching.

## Interface
- `ADDR`, 7'h42: target address matched against the first byte after START.
- `SYNC_STAGES`, 2: synchronizer depth on SCL/SDA inputs (≥2).
- `CLK_100MHz` in 1: system clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `i2c_scl` inout 1: bus clock; input only, always high-Z.
- `i2c_sda` inout 1: bus data; driven 0 or high-Z, never driven 1.
- `tx_data` in 8: byte to send on read; sampled on the `tx_req` cycle.
- `rx_data` out 8: last byte written by the controller.
- `rx_valid` out 1: one-cycle pulse, `rx_data` updated.
- `tx_req` out 1: one-cycle pulse, `tx_data` captured this cycle.
- `addr_hit` out 1: one-cycle pulse on address match; `rw` valid from this cycle.
- `rw` out 1: R/W bit of the current transaction (1 = read).
- `busy` out 1: high from address match until STOP or the next START.

## Operation
- Input path: `SYNC_STAGES` flops per line, then one edge-detect register. Events: `scl_rise`, `scl_fall`, `start` (SDA fall while SCL high), `stop` (SDA rise while SCL high).
- Bus sampling on `scl_rise`; SDA output changes only on `scl_fall`.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits MSB first.
  - ADDR_ACK: entered on the 8th bit. On match, drive SDA low on the next `scl_fall`, then release it on the following `scl_fall`. On mismatch, go to WAIT_STOP with SDA released.
  - WRITE: shift 8 bits. On the 8th rise, update `rx_data` and pulse `rx_valid`.
  - WRITE_ACK: always ACK (drive low for one bit), then return to WRITE.
  - READ: on the `scl_fall` that ends ADDR_ACK or READ_ACK, capture `tx_data` and pulse `tx_req`. Drive bit 7 immediately, then the next bit on each `scl_fall`. After 8 bits, release SDA.
  - READ_ACK: sample the controller's bit on `scl_rise`. 0 = continue to READ; 1 (NACK) = go to WAIT_STOP.
  - WAIT_STOP: SDA released; ignore all traffic.
- Bit counter is 3 bits and wraps 7→0 at each byte boundary.
- START is honoured in every state, including repeated START: go to ADDR, clear the bit counter, release SDA, deassert `busy`.
- STOP is honoured in every state: go to IDLE, release SDA, deassert `busy`.
- General call (address 0) and 10-bit addressing are not supported; both are treated as a mismatch.

## Timing
- Reset values: `rx_data`=0, `rx_valid`=0, `tx_req`=0, `addr_hit`=0, `rw`=0, `busy`=0, SDA released, state IDLE.
- `rst` mid-transfer: SDA is released one clock after `rst` is sampled high. After `rst` falls, the target stays in IDLE until a fresh START.
- Detection latency: a pin edge reaches the event strobes `SYNC_STAGES`+1 clocks later.
- SDA drive latency: 1 clock after `scl_fall`. This gives about 30 ns hold, well inside the 100/400 kHz SCL low time.
- `rx_valid` and `addr_hit` rise 1 clock after the `scl_rise` of the 8th bit.
- `tx_req` and `tx_data` capture occur on the same clock. Fabric must hold `tx_data` stable from the end of the ACK bit until that clock.
- START and STOP are mutually exclusive on a single clock. If a START or STOP coincides with a `scl_rise`, the START/STOP takes priority.

## Structure
- A shared package `i2c_pkg` holds the state encoding, bit-counter width, and the R/W bit position. The controller adopts the same package.
- One natural sub-module, `i2c_bus_sync`: synchronizer plus edge/START/STOP detector, reusable by the controller.
- Pins are driven through the existing `InOut` tristate primitive.
- Estimated size: about 200 lines of RTL.

## Test plan
- Write: START, 0x84, 0xA5, STOP → ACK on both bytes; `addr_hit`=1 with `rw`=0; `rx_data`=0xA5 with one `rx_valid` pulse; `busy` low after STOP.
- Read: START, 0x85 with `tx_data`=0x3C, controller NACKs → SDA bits 0,0,1,1,1,1,0,0; `tx_req` pulses once; WAIT_STOP; SDA released.
- Address mismatch: START, 0x90, 0x11 → no ACK, no `rx_valid`, SDA never driven.
- Repeated START: write 0x84, 0x01, then START, 0x85 with `tx_data`=0xF0 → `rx_data`=0x01; second `addr_hit` with `rw`=1; 0xF0 shifted out.
- Multi-byte read with ACK: `tx_data` 0x12 then 0x34, controller ACKs the first byte and NACKs the second → two `tx_req` pulses; both bytes correct on SDA.
- Reset mid-byte: assert `rst` during the 4th data bit of a write → SDA released within 1 clock; no `rx_valid`; next full transaction succeeds.
